fetch_sequencer: RTL and testbench

- Instruction-fetch end of the control-unit interface: consumes the decoded pc_op, b_jmp, halt and if_flush controls; owns the PC, the instruction-memory address and the IF/ID pipeline register.
- Implements next-PC selection, redirect squashing, hazard stalls and the halt state machine.
- Sits between instruction memory and the ID stage; the control unit in ID drives its redirect/halt inputs; the hazard unit drives stall.

---
 rtl/fetch_sequencer.sv | 89 ++++++++
 tb/tb_fetch_sequencer.sv | 137 +++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the PC and the IF/ID register (next-PC selection, redirect squash, stall, halt)
// Ports: clk, reset (sync, active-low); stall from the hazard unit; pc_op/b_jmp/branch_target/
// jump_target/halt/if_flush from the ID control unit; imem_rdata/imem_addr to instruction memory;
// pc, ifid_instr, ifid_pc_plus, ifid_valid to ID; halted status; fetch_count of valid fetches.
module fetch_sequencer #(
    parameter int ADDR_W = 16,
    parameter int INSTR_W = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(16'h8000),
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               pc_op,
    input  logic               b_jmp,
    input  logic [ADDR_W-1:0]  branch_target,
    input  logic [ADDR_W-1:0]  jump_target,
    input  logic               halt,
    input  logic               if_flush,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic [ADDR_W-1:0]  pc,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic [ADDR_W-1:0]  ifid_pc_plus,
    output logic               ifid_valid,
    output logic               halted,
    output logic [CNT_W-1:0]   fetch_count
);
    typedef enum logic {RUN, HALTED} state_t;
    state_t state, state_nxt;
    logic [ADDR_W-1:0] pc_nxt, plus_nxt, pc_plus2;
    logic [INSTR_W-1:0] instr_nxt;
    logic valid_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    assign imem_addr = pc;
    assign halted = state == HALTED;
    assign pc_plus2 = pc + ADDR_W'(2);
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= RUN;
            pc <= RESET_PC;
            ifid_instr <= NOP_INSTR;
            ifid_pc_plus <= '0;
            ifid_valid <= 1'b0;
            fetch_count <= '0;
        end else begin
            state <= state_nxt;
            pc <= pc_nxt;
            ifid_instr <= instr_nxt;
            ifid_pc_plus <= plus_nxt;
            ifid_valid <= valid_nxt;
            fetch_count <= cnt_nxt;
        end
    end
    // Bubbles leave ifid_pc_plus untouched; only valid fetches refresh it.
    always_comb begin
        state_nxt = state;
        pc_nxt = pc;
        instr_nxt = ifid_instr;
        plus_nxt = ifid_pc_plus;
        valid_nxt = ifid_valid;
        cnt_nxt = fetch_count;
        if (state == RUN) begin
            if (halt) begin
                state_nxt = HALTED;
                instr_nxt = NOP_INSTR;
                valid_nxt = 1'b0;
            end else if (pc_op) begin
                pc_nxt = b_jmp ? branch_target : jump_target;
                instr_nxt = NOP_INSTR;
                valid_nxt = 1'b0;
            end else if (stall) begin
                instr_nxt = if_flush ? NOP_INSTR : ifid_instr;
                valid_nxt = if_flush ? 1'b0 : ifid_valid;
            end else if (if_flush) begin
                pc_nxt = pc_plus2;
                instr_nxt = NOP_INSTR;
                valid_nxt = 1'b0;
            end else begin
                pc_nxt = pc_plus2;
                instr_nxt = imem_rdata;
                plus_nxt = pc_plus2;
                valid_nxt = 1'b1;
                cnt_nxt = &fetch_count ? fetch_count : fetch_count + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed checks of fetch_sequencer (default, wrap-start and 2-bit counter instances)
module tb_fetch_sequencer;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic stall = 1'b0, pc_op = 1'b0, b_jmp = 1'b0, halt = 1'b0, if_flush = 1'b0;
    logic [15:0] branch_target = '0, jump_target = '0;
    logic fix = 1'b1;
    int checks = 0;
    int failures = 0;
    logic [15:0] rd_m, addr_m, pc_m, instr_m, plus_m;
    logic valid_m, halted_m;
    logic [15:0] cnt_m;
    logic [15:0] rd_w, addr_w, pc_w, instr_w, plus_w, cnt_w;
    logic valid_w, halted_w;
    logic [15:0] rd_c, addr_c, pc_c, instr_c, plus_c;
    logic valid_c, halted_c;
    logic [1:0] cnt_c;
    always #5 clk = ~clk;
    assign rd_m = fix ? 16'hF123 : (addr_m ^ 16'h5A00);
    assign rd_w = fix ? 16'hF123 : (addr_w ^ 16'h5A00);
    assign rd_c = fix ? 16'hF123 : (addr_c ^ 16'h5A00);
    fetch_sequencer dut (
        .clk(clk), .reset(reset), .stall(stall), .pc_op(pc_op), .b_jmp(b_jmp),
        .branch_target(branch_target), .jump_target(jump_target), .halt(halt), .if_flush(if_flush),
        .imem_rdata(rd_m), .imem_addr(addr_m), .pc(pc_m), .ifid_instr(instr_m),
        .ifid_pc_plus(plus_m), .ifid_valid(valid_m), .halted(halted_m), .fetch_count(cnt_m));
    fetch_sequencer #(.RESET_PC(16'hFFFC)) dut_w (
        .clk(clk), .reset(reset), .stall(stall), .pc_op(pc_op), .b_jmp(b_jmp),
        .branch_target(branch_target), .jump_target(jump_target), .halt(halt), .if_flush(if_flush),
        .imem_rdata(rd_w), .imem_addr(addr_w), .pc(pc_w), .ifid_instr(instr_w),
        .ifid_pc_plus(plus_w), .ifid_valid(valid_w), .halted(halted_w), .fetch_count(cnt_w));
    fetch_sequencer #(.CNT_W(2)) dut_c (
        .clk(clk), .reset(reset), .stall(stall), .pc_op(pc_op), .b_jmp(b_jmp),
        .branch_target(branch_target), .jump_target(jump_target), .halt(halt), .if_flush(if_flush),
        .imem_rdata(rd_c), .imem_addr(addr_c), .pc(pc_c), .ifid_instr(instr_c),
        .ifid_pc_plus(plus_c), .ifid_valid(valid_c), .halted(halted_c), .fetch_count(cnt_c));
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic do_reset();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask
    task automatic check_ifid(input string tag, input logic [15:0] p, input logic [15:0] ins,
                              input logic [15:0] pp, input logic v);
        check({tag, "_pc"}, 32'(pc_m), 32'(p));
        check({tag, "_addr"}, 32'(addr_m), 32'(p));
        check({tag, "_instr"}, 32'(instr_m), 32'(ins));
        if (v) check({tag, "_plus"}, 32'(plus_m), 32'(pp));
        check({tag, "_valid"}, 32'(valid_m), 32'(v));
    endtask
    initial begin
        logic [15:0] wexp [1:3];
        logic [1:0] cexp [1:5];
        wexp[1] = 16'hFFFE; wexp[2] = 16'h0000; wexp[3] = 16'h0002;
        cexp[1] = 2'd1; cexp[2] = 2'd2; cexp[3] = 2'd3; cexp[4] = 2'd3; cexp[5] = 2'd3;
        do_reset();
        reset = 1'b0;
        step();
        check("rst_pc", 32'(pc_m), 32'h0);
        check("rst_instr", 32'(instr_m), 32'h8000);
        check("rst_plus", 32'(plus_m), 32'h0);
        check("rst_valid", 32'(valid_m), 32'h0);
        check("rst_halted", 32'(halted_m), 32'h0);
        check("rst_cnt", 32'(cnt_m), 32'h0);
        check("rst_pc_w", 32'(pc_w), 32'hFFFC);
        reset = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step();
            check_ifid($sformatf("free%0d", k), 16'(2 * k), 16'hF123, 16'(2 * k), 1'b1);
            check($sformatf("free%0d_cnt", k), 32'(cnt_m), 32'(k));
            check($sformatf("cnt2_%0d", k), 32'(cnt_c), 32'(cexp[k]));
            if (k <= 3) check($sformatf("wrap%0d", k), 32'(pc_w), 32'(wexp[k]));
        end
        fix = 1'b0;
        do_reset();
        step(); step(); step();
        check("pre_br_pc", 32'(pc_m), 32'h6);
        pc_op = 1'b1; b_jmp = 1'b1; branch_target = 16'h0040; jump_target = 16'h0BAD;
        step();
        check_ifid("br", 16'h0040, 16'h8000, 16'h0, 1'b0);
        pc_op = 1'b0;
        step();
        check_ifid("br_tgt", 16'h0042, 16'h5A40, 16'h0042, 1'b1);
        check("br_cnt", 32'(cnt_m), 32'd4);
        do_reset();
        step(); step();
        check_ifid("pre_st", 16'h0004, 16'h5A02, 16'h0004, 1'b1);
        stall = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step();
            check_ifid($sformatf("st%0d", k), 16'h0004, 16'h5A02, 16'h0004, 1'b1);
        end
        if_flush = 1'b1;
        step();
        check_ifid("st_fl", 16'h0004, 16'h8000, 16'h0, 1'b0);
        if_flush = 1'b0; pc_op = 1'b1; b_jmp = 1'b0; jump_target = 16'h0100; branch_target = 16'h0BAD;
        step();
        check_ifid("st_jmp", 16'h0100, 16'h8000, 16'h0, 1'b0);
        stall = 1'b0; pc_op = 1'b0;
        step();
        check_ifid("jmp_tgt", 16'h0102, 16'h5B00, 16'h0102, 1'b1);
        if_flush = 1'b1;
        step();
        check_ifid("flush", 16'h0104, 16'h8000, 16'h0, 1'b0);
        check("flush_cnt", 32'(cnt_m), 32'd3);
        if_flush = 1'b0; halt = 1'b1; pc_op = 1'b1; b_jmp = 1'b1; branch_target = 16'h0200;
        step();
        check("halt_halted", 32'(halted_m), 32'h1);
        check_ifid("halt", 16'h0104, 16'h8000, 16'h0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            halt = k[0]; pc_op = k[1]; stall = k[2]; if_flush = k[0] ^ k[1]; b_jmp = ~k[0];
            step();
        end
        check("hd_halted", 32'(halted_m), 32'h1);
        check_ifid("hd", 16'h0104, 16'h8000, 16'h0, 1'b0);
        check("hd_cnt", 32'(cnt_m), 32'd3);
        reset = 1'b0;
        step();
        check("hrst_pc", 32'(pc_m), 32'h0);
        check("hrst_halted", 32'(halted_m), 32'h0);
        check("hrst_cnt", 32'(cnt_m), 32'h0);
        check("hrst_valid", 32'(valid_m), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
